// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit: one aligned memory op at a time, from the execute stage to the RAM bus and back to writeback.
// Latency: misaligned result 1 cycle after accept, store 1 cycle after grant, load 1 cycle after rvalid.
// Backpressure: accepts only in IDLE; the result is held in RESP until out_ready; the bus request is held until mem_gnt.
module ysyx_22040125_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [63:0] in_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wstrb,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_misalign,
  output logic        out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // The counter only has to reach TIMEOUT-1, so TIMEOUT itself bounds its width.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_q, load_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [2:0]    off_q, off_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wstrb_q, mem_wstrb_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;
  logic [63:0]   out_data_q, out_data_d;
  logic          out_misalign_q, out_misalign_d;
  logic          out_err_q, out_err_d;
  logic          timeout_hit;

  // Natural alignment: the low log2(size) address bits must be zero.
  function automatic logic misaligned_f(input logic [1:0] size, input logic [2:0] a);
    logic m;
    case (size)
      2'd0:    m = 1'b0;
      2'd1:    m = a[0];
      2'd2:    m = |a[1:0];
      default: m = |a;
    endcase
    return m;
  endfunction

  // Byte enables for the accessed bytes within the doubleword.
  function automatic logic [7:0] strobe_f(input logic [1:0] size, input logic [2:0] a);
    logic [7:0] s;
    case (size)
      2'd0:    s = 8'h01 << a;
      2'd1:    s = 8'h03 << a;
      2'd2:    s = 8'h0F << a;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Replicate the right-justified store data across every lane so the strobes pick the right bytes.
  function automatic logic [63:0] repl_f(input logic [1:0] size, input logic [63:0] d);
    logic [63:0] r;
    case (size)
      2'd0:    r = {8{d[7:0]}};
      2'd1:    r = {4{d[15:0]}};
      2'd2:    r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend to 64 bits.
  function automatic logic [63:0] fmt_f(input logic [1:0] size, input logic uns,
                                        input logic [2:0] a, input logic [63:0] rd);
    logic [63:0] lane;
    logic [63:0] v;
    lane = rd >> {a, 3'b000};
    case (size)
      2'd0:    v = uns ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'd1:    v = uns ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2:    v = uns ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: v = lane;
    endcase
    return v;
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Handshake outputs are pure state decodes so they drop the instant reset asserts.
  assign in_ready     = (state_q == S_IDLE);
  assign mem_req      = (state_q == S_REQ);
  assign out_valid    = (state_q == S_RESP);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign mem_wdata    = mem_wdata_q;
  assign out_data     = out_data_q;
  assign out_misalign = out_misalign_q;
  assign out_err      = out_err_q;

  // Next-state and next-datapath logic; every register holds unless its state acts on it.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load_d         = load_q;
    size_d         = size_q;
    uns_d          = uns_q;
    off_d          = off_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wstrb_d    = mem_wstrb_q;
    mem_wdata_d    = mem_wdata_q;
    out_data_d     = out_data_q;
    out_misalign_d = out_misalign_q;
    out_err_d      = out_err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load_d     = in_load;
          size_d     = in_size;
          uns_d      = in_unsigned;
          off_d      = in_addr[2:0];
          cnt_d      = '0;
          out_data_d = '0;
          out_err_d  = 1'b0;
          if (misaligned_f(in_size, in_addr[2:0])) begin
            // Bus fields are left alone: no request is ever made for this op.
            out_misalign_d = 1'b1;
            state_d        = S_RESP;
          end else begin
            out_misalign_d = 1'b0;
            mem_we_d       = ~in_load;
            mem_addr_d     = {in_addr[31:3], 3'b000};
            mem_wstrb_d    = in_load ? 8'h00 : strobe_f(in_size, in_addr[2:0]);
            mem_wdata_d    = in_load ? 64'd0 : repl_f(in_size, in_wdata);
            state_d        = S_REQ;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_gnt && !load_q) begin
          state_d = S_RESP;
        end else if (timeout_hit) begin
          // A load grant is not completion, so the timeout still wins for loads here.
          out_err_d  = 1'b1;
          out_data_d = '0;
          state_d    = S_RESP;
        end else if (mem_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid) begin
          out_data_d = fmt_f(size_q, uns_q, off_q, mem_rdata);
          state_d    = S_RESP;
        end else if (timeout_hit) begin
          out_err_d  = 1'b1;
          out_data_d = '0;
          state_d    = S_RESP;
        end
      end

      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // FSM state and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched operation, bus request fields and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q         <= 1'b0;
      size_q         <= 2'd0;
      uns_q          <= 1'b0;
      off_q          <= 3'd0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_wstrb_q    <= 8'd0;
      mem_wdata_q    <= 64'd0;
      out_data_q     <= 64'd0;
      out_misalign_q <= 1'b0;
      out_err_q      <= 1'b0;
    end else begin
      load_q         <= load_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      off_q          <= off_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wstrb_q    <= mem_wstrb_d;
      mem_wdata_q    <= mem_wdata_d;
      out_data_q     <= out_data_d;
      out_misalign_q <= out_misalign_d;
      out_err_q      <= out_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Testbench for the load/store unit: directed bus scenarios plus randomized ops against a byte-level model.
// Latency: results expected on the cycle derived from grant/rvalid delays and the 4-cycle timeout.
// Backpressure: out_ready is withheld for random cycles while in_valid and stray bus strobes are offered.
module tb_ysyx_22040125_lsu;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [63:0] in_wdata;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_misalign;
  logic        out_err;

  int checks   = 0;
  int failures = 0;

  ysyx_22040125_lsu #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_load      (in_load),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_misalign (out_misalign),
    .out_err      (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: the accessed bytes are [a, a+n) of the doubleword.
  function automatic logic [7:0] ref_strb(input bit ld, input logic [1:0] sz, input logic [2:0] a);
    logic [7:0] s;
    int n;
    s = 8'h00;
    n = 1 << sz;
    if (!ld)
      for (int i = 0; i < 8; i++)
        if (i >= int'(a) && i < int'(a) + n) s[i] = 1'b1;
    return s;
  endfunction

  // Reference: every byte lane i carries source byte (i mod n).
  function automatic logic [63:0] ref_wdata(input logic [1:0] sz, input logic [63:0] d);
    logic [63:0] v;
    int n;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = d[8*(i % n) +: 8];
    return v;
  endfunction

  // Reference: gather n bytes starting at byte a, then fill upper bytes with 0xFF if signed and negative.
  function automatic logic [63:0] ref_load(input logic [1:0] sz, input bit uns,
                                           input logic [2:0] a, input logic [63:0] rd);
    logic [63:0] v;
    int n;
    bit neg;
    n = 1 << sz;
    v = '0;
    for (int j = 0; j < n; j++) v[8*j +: 8] = rd[8*(int'(a) + j) +: 8];
    neg = !uns && (n < 8) && v[8*n - 1];
    if (neg)
      for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  // One operation: g = cycles of grant delay, r = cycles from grant to rvalid, hold = cycles of out_ready low.
  task automatic run_op(input string nm, input bit ld, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [63:0] wd, input int g, input int r,
                        input logic [63:0] rd, input int hold);
    int          n;
    bit          mis;
    bit          exp_err;
    int          exp_cycle;
    logic [63:0] exp_data;
    int          cyc;
    n         = 1 << sz;
    mis       = (addr % n) != 0;
    exp_err   = 1'b0;
    exp_data  = '0;
    if (mis) begin
      exp_cycle = 1;
    end else if (!ld) begin
      if (g + 1 <= TO) exp_cycle = g + 2;
      else begin exp_err = 1'b1; exp_cycle = TO + 1; end
    end else begin
      if (g + 1 + r <= TO) begin
        exp_cycle = g + r + 2;
        exp_data  = ref_load(sz, uns, addr[2:0], rd);
      end else begin
        exp_err = 1'b1; exp_cycle = TO + 1;
      end
    end

    chk({nm, ":idle_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_load = ld; in_size = sz; in_unsigned = uns;
    in_addr = addr; in_wdata = wd; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    in_addr = $urandom; in_wdata = {$urandom, $urandom};
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      chk({nm, ":busy_in_ready"}, in_ready, 0);
      if (!mis) begin
        chk({nm, ":mem_req"}, mem_req, (cyc <= g + 1) ? 1 : 0);
        if (mem_req === 1'b1) begin
          chk({nm, ":mem_we"},    mem_we, ld ? 0 : 1);
          chk({nm, ":mem_addr"},  mem_addr, {addr[31:3], 3'b000});
          chk({nm, ":mem_wstrb"}, mem_wstrb, ref_strb(ld, sz, addr[2:0]));
          if (!ld) chk({nm, ":mem_wdata"}, mem_wdata, ref_wdata(sz, wd));
        end
      end
      mem_gnt    = (cyc == g + 1);
      mem_rvalid = ld && (cyc == g + 1 + r);
      mem_rdata  = mem_rvalid ? rd : {$urandom, $urandom};
      tick;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      cyc++;
    end
    chk({nm, ":out_cycle"}, cyc, exp_cycle);

    for (int h = 0; h <= hold; h++) begin
      chk({nm, ":out_valid"},    out_valid, 1);
      chk({nm, ":out_data"},     out_data, exp_data);
      chk({nm, ":out_misalign"}, out_misalign, mis);
      chk({nm, ":out_err"},      out_err, exp_err);
      chk({nm, ":resp_in_ready"}, in_ready, 0);
      chk({nm, ":resp_mem_req"}, mem_req, 0);
      if (h < hold) begin
        in_valid = 1'b1; in_load = $urandom; in_size = $urandom; in_addr = $urandom;
        mem_gnt = $urandom; mem_rvalid = $urandom; mem_rdata = {$urandom, $urandom};
        tick;
      end
    end
    in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({nm, ":done_out_valid"}, out_valid, 0);
    chk({nm, ":done_in_ready"},  in_ready, 1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ":rst_mem_req"},   mem_req, 0);
    chk({nm, ":rst_mem_we"},    mem_we, 0);
    chk({nm, ":rst_mem_addr"},  mem_addr, 0);
    chk({nm, ":rst_mem_wstrb"}, mem_wstrb, 0);
    chk({nm, ":rst_mem_wdata"}, mem_wdata, 0);
    chk({nm, ":rst_out_valid"}, out_valid, 0);
    chk({nm, ":rst_out_data"},  out_data, 0);
    chk({nm, ":rst_misalign"},  out_misalign, 0);
    chk({nm, ":rst_err"},       out_err, 0);
    chk({nm, ":rst_in_ready"},  in_ready, 1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    out_ready = 1'b0;
    tick; tick;
    chk_reset_vals("por");
    rst_n = 1'b1;
    tick;

    // Directed scenarios.
    run_op("lb_0x103",   1, 2'd0, 0, 32'h103, '0, 0, 1, 64'h0000_0000_8000_0000, 0);
    run_op("lbu_0x103",  1, 2'd0, 1, 32'h103, '0, 0, 1, 64'h0000_0000_8000_0000, 0);
    run_op("sh_0x206",   0, 2'd1, 0, 32'h206, 64'h1234_ABCD, 2, 1, '0, 0);
    run_op("lw_mis",     1, 2'd2, 0, 32'h102, '0, 0, 1, 64'hDEAD_BEEF_0000_0000, 0);
    run_op("ld_timeout", 1, 2'd3, 0, 32'h108, '0, 0, 10, 64'h1122_3344_5566_7788, 0);
    run_op("ld_last_cyc", 1, 2'd3, 0, 32'h108, '0, 0, 3, 64'h1122_3344_5566_7788, 0);
    run_op("ld_hold",    1, 2'd3, 0, 32'h110, '0, 0, 1, 64'hFEDC_BA98_7654_3210, 3);
    run_op("sd_zero",    0, 2'd3, 0, 32'h118, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1, '0, 0);
    run_op("sw_timeout", 0, 2'd2, 0, 32'h124, 64'h0BAD_F00D, 4, 1, '0, 0);
    run_op("lh_neg",     1, 2'd1, 0, 32'h10E, '0, 1, 2, 64'h8001_0000_0000_0000, 1);

    // Reset while the request is outstanding: mem_req must fall without a clock edge.
    in_valid = 1'b1; in_load = 1'b0; in_size = 2'd3; in_addr = 32'h200; in_wdata = 64'h55;
    tick;
    in_valid = 1'b0;
    chk("rstreq:mem_req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstreq");
    tick;
    rst_n = 1'b1;
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    chk("rstreq:late_gnt_out_valid", out_valid, 0);
    chk("rstreq:late_gnt_in_ready", in_ready, 1);

    // Reset while waiting for read data: a late rvalid must be ignored.
    in_valid = 1'b1; in_load = 1'b1; in_size = 2'd3; in_addr = 32'h108;
    tick;
    in_valid = 1'b0; mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    chk("rstwait:in_wait_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstwait");
    tick;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    mem_rvalid = 1'b0;
    chk("rstwait:late_rvalid_out_valid", out_valid, 0);
    chk("rstwait:late_rvalid_in_ready", in_ready, 1);
    chk("rstwait:late_rvalid_out_data", out_data, 0);
    tick;

    // Randomized ops, mostly aligned so the bus path sees most of the traffic.
    for (int k = 0; k < 60; k++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      run_op("rnd", bit'($urandom_range(0, 1)), sz, bit'($urandom_range(0, 1)), ad,
             {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(1, 4),
             {$urandom, $urandom}, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
